// File: rtl/z80_io_master.sv
// Z80 IO bus master: runs one IN/OUT bus cycle (T1, T2, TW, T3) per request.
// Build option: define Z80IO_WAIT_EN to make TW repeat while n_wait is low.
module z80_io_master #(
  parameter int unsigned CLK_PER_T = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic [15:0] a,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in,
  output logic        n_iorq,
  output logic        n_rd,
  output logic        n_wr,
  output logic        n_m1,
  input  logic        n_wait
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_T - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wr_q;
  logic             t_last_c;
  logic             wait_hold_c;

  assign t_last_c = (cnt == CNT_LAST);

`ifdef Z80IO_WAIT_EN
  assign wait_hold_c = ~n_wait;
`else
  // n_wait has no effect in this build; tie it off visibly.
  logic unused_n_wait;
  assign unused_n_wait = n_wait;
  assign wait_hold_c   = 1'b0;
`endif

  // Bus-cycle sequencer; every output is updated on the transition that enters its phase.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_data <= 8'h00;
      a       <= 16'h0000;
      d_out   <= 8'h00;
      d_oe    <= 1'b0;
      n_iorq  <= 1'b1;
      n_rd    <= 1'b1;
      n_wr    <= 1'b1;
      n_m1    <= 1'b1;
    end else begin
      done <= 1'b0;
      n_m1 <= 1'b1;
      if (state != S_IDLE) begin
        cnt <= t_last_c ? '0 : cnt + CNT_W'(1);
      end
      case (state)
        S_IDLE: begin
          if (req) begin
            state <= S_T1;
            cnt   <= '0;
            wr_q  <= req_wr;
            busy  <= 1'b1;
            a     <= req_addr;
            d_oe  <= req_wr;
            d_out <= req_wr ? req_data : 8'h00;
          end
        end
        S_T1: begin
          if (t_last_c) begin
            state  <= S_T2;
            n_iorq <= 1'b0;
            n_wr   <= ~wr_q;
            n_rd   <= wr_q;
          end
        end
        S_T2: begin
          if (t_last_c) begin
            state <= S_TW;
          end
        end
        S_TW: begin
          if (t_last_c && !wait_hold_c) begin
            state <= S_T3;
          end
        end
        S_T3: begin
          if (t_last_c) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            a      <= 16'h0000;
            d_oe   <= 1'b0;
            d_out  <= 8'h00;
            n_iorq <= 1'b1;
            n_rd   <= 1'b1;
            n_wr   <= 1'b1;
            if (!wr_q) begin
              rd_data <= d_in;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z80_io_master.sv
// Self-checking bench for z80_io_master (CLK_PER_T = 2) against a cycle-count reference model.
module tb_z80_io_master;

  localparam int unsigned P = 2;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        req = 1'b0;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_data = 8'h00;
  logic [7:0]  d_in = 8'h00;
  logic        n_wait = 1'b1;
  logic        busy, done, d_oe, n_iorq, n_rd, n_wr, n_m1;
  logic [7:0]  rd_data, d_out;
  logic [15:0] a;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  exp_rd = 8'h00;

  always #5 clk = ~clk;

  z80_io_master #(.CLK_PER_T(P)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_data(req_data), .busy(busy), .done(done), .rd_data(rd_data), .a(a),
    .d_out(d_out), .d_oe(d_oe), .d_in(d_in), .n_iorq(n_iorq), .n_rd(n_rd),
    .n_wr(n_wr), .n_m1(n_m1), .n_wait(n_wait)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Whole bus cycle from request to done; model: (4 + extra TW) T-states of P clks each.
  task automatic run_cycle(input bit wr, input logic [15:0] addr, input logic [7:0] data,
                           input logic [7:0] din, input int lows, input string tag);
    int  extra, exp_len, exp_io;
    int  n_busy, n_a, n_bad_a, n_io, n_wr_lo, n_rd_lo, n_oe, n_bad_do, n_m1_lo, idx;
    bit  got_done;
`ifdef Z80IO_WAIT_EN
    extra = lows;
`else
    extra = 0;
`endif
    exp_len = (4 + extra) * P;
    exp_io  = (3 + extra) * P;
    n_busy = 0; n_a = 0; n_bad_a = 0; n_io = 0; n_wr_lo = 0; n_rd_lo = 0;
    n_oe = 0; n_bad_do = 0; n_m1_lo = 0; idx = 0; got_done = 0;
    req = 1'b1; req_wr = wr; req_addr = addr; req_data = data; d_in = din; n_wait = 1'b1;
    @(negedge clk);
    req = 1'b0; req_addr = 16'($urandom); req_data = 8'($urandom); req_wr = 1'($urandom);
    for (int g = 0; g < 400 && !got_done; g++) begin
      if (done === 1'b1) begin
        got_done = 1;
      end else begin
        if (busy === 1'b1) n_busy++;
        if (a === addr) n_a++; else n_bad_a++;
        if (n_wr === 1'b0) n_wr_lo++;
        if (n_rd === 1'b0) n_rd_lo++;
        if (n_m1 !== 1'b1) n_m1_lo++;
        if (d_oe === 1'b1) begin
          n_oe++;
          if (d_out !== data) n_bad_do++;
        end
        if (n_iorq === 1'b0) begin
          n_wait = (lows > 0 && idx < int'(P) * (1 + lows)) ? 1'b0 : 1'b1;
          idx++;
          n_io++;
        end else begin
          n_wait = 1'b1;
        end
        @(negedge clk);
      end
    end
    n_wait = 1'b1;
    if (!wr) exp_rd = din;
    n_tests++; if (!got_done) begin n_fail++; $display("FAIL %s timeout: no done within 400 clks", tag); end
    n_tests++; if (n_busy != exp_len) begin n_fail++; $display("FAIL %s busy_len got %0d want %0d", tag, n_busy, exp_len); end
    n_tests++; if (n_a != exp_len || n_bad_a != 0) begin n_fail++; $display("FAIL %s addr_len got %0d (bad %0d) want %0d", tag, n_a, n_bad_a, exp_len); end
    n_tests++; if (n_io != exp_io) begin n_fail++; $display("FAIL %s iorq_len got %0d want %0d", tag, n_io, exp_io); end
    n_tests++; if ((wr ? n_wr_lo : n_rd_lo) != exp_io) begin n_fail++; $display("FAIL %s strobe_len got %0d want %0d", tag, wr ? n_wr_lo : n_rd_lo, exp_io); end
    n_tests++; if ((wr ? n_rd_lo : n_wr_lo) != 0) begin n_fail++; $display("FAIL %s other_strobe got %0d want 0", tag, wr ? n_rd_lo : n_wr_lo); end
    n_tests++; if (n_oe != (wr ? exp_len : 0) || n_bad_do != 0) begin n_fail++; $display("FAIL %s d_oe_len got %0d (bad data %0d) want %0d", tag, n_oe, n_bad_do, wr ? exp_len : 0); end
    n_tests++; if (n_m1_lo != 0) begin n_fail++; $display("FAIL %s n_m1 low count got %0d want 0", tag, n_m1_lo); end
    n_tests++; if (busy !== 1'b0 || a !== 16'h0000 || n_iorq !== 1'b1 || d_oe !== 1'b0) begin
      n_fail++; $display("FAIL %s idle_at_done busy=%b a=%h n_iorq=%b d_oe=%b want 0/0000/1/0", tag, busy, a, n_iorq, d_oe); end
    n_tests++; if (rd_data !== exp_rd) begin n_fail++; $display("FAIL %s rd_data got %h want %h", tag, rd_data, exp_rd); end
    @(negedge clk);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s done_width got done=%b on 2nd clk want 0", tag, done); end
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || rd_data !== 8'h00 || a !== 16'h0000 || d_out !== 8'h00 || d_oe !== 1'b0
                   || n_iorq !== 1'b1 || n_rd !== 1'b1 || n_wr !== 1'b1 || n_m1 !== 1'b1) begin
      n_fail++; $display("FAIL reset_state busy=%b done=%b rd=%h a=%h do=%h oe=%b io=%b rd=%b wr=%b m1=%b",
                         busy, done, rd_data, a, d_out, d_oe, n_iorq, n_rd, n_wr, n_m1);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_spec_vectors();
    run_cycle(1'b1, 16'hFFFD, 8'h07, 8'h00, 0, "write_fffd");
    run_cycle(1'b0, 16'h00CF, 8'h00, 8'h5A, 0, "read_00cf");
    run_cycle(1'b0, 16'h1234, 8'h00, 8'hA5, 3, "wait_3");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset_abort();
    bit seen_io, seen_done;
    seen_io = 0; seen_done = 0;
    req = 1'b1; req_wr = 1'b1; req_addr = 16'hBEEF; req_data = 8'h3C;
    @(negedge clk);
    req = 1'b0;
    for (int g = 0; g < 20 && !seen_io; g++) begin
      if (n_iorq === 1'b0) seen_io = 1; else @(negedge clk);
    end
    n_tests++; if (!seen_io) begin n_fail++; $display("FAIL abort_reach_t2 n_iorq never low within 20 clks"); end
    #1 n_rst = 1'b0;
    #1;
    exp_rd = 8'h00;
    n_tests++; if (busy !== 1'b0 || a !== 16'h0000 || d_oe !== 1'b0 || n_iorq !== 1'b1 || n_wr !== 1'b1 || n_rd !== 1'b1 || n_m1 !== 1'b1) begin
      n_fail++; $display("FAIL abort_async busy=%b a=%h oe=%b io=%b wr=%b rd=%b m1=%b want 0/0000/0/1/1/1/1", busy, a, d_oe, n_iorq, n_wr, n_rd, n_m1);
    end
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1;
    end
    n_rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1;
    end
    n_tests++; if (seen_done) begin n_fail++; $display("FAIL abort_no_done got done/busy after reset want none"); end
    run_cycle(1'b1, 16'h0102, 8'h99, 8'h00, 0, "after_abort");
  endtask

  task automatic test_back_to_back();
    bit got_done;
    int n_bad_a;
    got_done = 0; n_bad_a = 0;
    req = 1'b1; req_wr = 1'b1; req_addr = 16'hA001; req_data = 8'h11;
    @(negedge clk);
    req_addr = 16'hB002; req_data = 8'h22;
    for (int g = 0; g < 100 && !got_done; g++) begin
      if (done === 1'b1) got_done = 1;
      else begin
        if (a !== 16'hA001) n_bad_a++;
        @(negedge clk);
      end
    end
    n_tests++; if (!got_done || n_bad_a != 0) begin n_fail++; $display("FAIL b2b_first got done=%b bad_addr=%0d want 1/0", got_done, n_bad_a); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_gap busy at done got %b want 0", busy); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b1 || a !== 16'hB002 || d_out !== 8'h22) begin
      n_fail++; $display("FAIL b2b_restart busy=%b a=%h d_out=%h want 1/b002/22", busy, a, d_out); end
    req = 1'b0;
    got_done = 0;
    for (int g = 0; g < 100 && !got_done; g++) begin
      @(negedge clk);
      if (done === 1'b1) got_done = 1;
    end
    n_tests++; if (!got_done) begin n_fail++; $display("FAIL b2b_second no done within 100 clks"); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop busy got %b want 0 with req low", busy); end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/z80_io_master.md
Z80_IO_MASTER -- requirements
Module: z80_io_master

Interface
REQ-001 SHALL have parameter CLK_PER_T, default 2: clk cycles per Z80 T-state; legal range 1..15.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  1  request strobe; sampled only in IDLE.
REQ-005 SHALL have port req_wr  input  1  1 = IO write, 0 = IO read.
REQ-006 SHALL have port req_addr  input  16  IO port address.
REQ-007 SHALL have port req_data  input  8  write data.
REQ-008 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-009 SHALL have port done  output  1  one-clk pulse on cycle completion.
REQ-010 SHALL have port rd_data  output  8  data captured by the last read.
REQ-011 SHALL have port a  output  16  bus address.
REQ-012 SHALL have port d_out  output  8  bus write data.
REQ-013 SHALL have port d_oe  output  1  data bus drive enable.
REQ-014 SHALL have port d_in  input  8  bus read data.
REQ-015 SHALL have ports n_iorq, n_rd, n_wr, n_m1  output  1 each  Z80 strobes, active-low.
REQ-016 SHALL have port n_wait  input  1  bus wait request, active-low.

Function
REQ-017 SHALL implement the states IDLE, T1, T2, TW, T3; each non-IDLE state lasts CLK_PER_T clks, timed by a T-state counter.
REQ-018 SHALL latch req_wr, req_addr and req_data, then move IDLE->T1 on the clk where req=1 in IDLE.
REQ-019 SHALL step T1->T2->TW->T3->IDLE. The single TW is the automatic IO wait state.
REQ-020 SHALL hold a = latched address from T1 through T3, and 16'h0000 in IDLE.
REQ-021 SHALL drive n_iorq low, plus n_wr (write) or n_rd (read), throughout T2, TW and T3; otherwise these SHALL be high.
REQ-022 SHALL hold n_m1 high at all times.
REQ-023 SHALL, for writes, hold d_oe=1 and d_out = latched data from T1 through T3; d_oe SHALL be 0 otherwise and for reads.
REQ-024 SHALL, for reads, load rd_data from d_in on the last clk of T3; rd_data SHALL hold its value until the next read.
REQ-025 SHALL pulse done for exactly one clk, registered, on the clk of the T3->IDLE transition.
REQ-026 SHALL ignore req outside IDLE, so at least one IDLE clk separates consecutive cycles.
REQ-027 SHALL keep the T-state counter 4 bits wide, wrapping to 0 at CLK_PER_T-1.

Reset
REQ-028 SHALL, while n_rst=0, force: state IDLE, counter 0, busy=0, done=0, rd_data=8'h00, a=16'h0000, d_out=8'h00, d_oe=0, and n_iorq=n_rd=n_wr=n_m1=1.
REQ-029 SHALL abort any cycle in progress when reset is asserted, with no done pulse, and SHALL resume from IDLE after reset is released.

Configuration
REQ-030 SHALL use the macro Z80IO_WAIT_EN.
REQ-031 With Z80IO_WAIT_EN defined: SHALL sample n_wait on the last clk of each TW and repeat TW while n_wait=0.
REQ-032 Without Z80IO_WAIT_EN: SHALL ignore n_wait; every cycle SHALL be exactly 4 T-states.

Verification (CLK_PER_T=2)
REQ-033 Write 0xFFFD, data 0x07 -> a=0xFFFD for 8 clks; n_iorq and n_wr low for 6 clks; d_oe high for 8 clks with d_out=0x07; done one clk later.
REQ-034 Read 0x00CF with d_in=0x5A -> n_rd low for 6 clks, d_oe=0, rd_data=0x5A on done.
REQ-035 With Z80IO_WAIT_EN, n_wait=0 for the first 3 TW samples -> n_iorq low 12 clks; without the macro -> n_iorq low 6 clks.
REQ-036 n_rst pulsed low mid-T2 of a write -> all strobes high and d_oe=0 immediately, no done; next req completes normally.
REQ-037 req held high continuously -> a new cycle starts only after an IDLE clk following done; mid-cycle changes to req_addr have no effect.
